// File: rtl/program_sequencer.sv
// Fetch/issue controller for the 4-bit program ROM with internal SNZA/SNZS skip resolution.
// Optional single-step gating of FETCH is enabled by defining SEQ_SINGLE_STEP_EN.
module program_sequencer #(
  parameter int ADDR_WIDTH = 8,
  parameter int PROG_END   = 15,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] romAddr,
  input  logic [3:0]            romData,
  output logic                  instr_valid,
  output logic [3:0]            instr_op,
  input  logic                  instr_ready,
  input  logic                  zero_a,
  input  logic                  zero_s,
  output logic                  busy,
  output logic                  done,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic                  step_en,
  input  logic                  step,
`endif
  output logic [CNT_WIDTH-1:0]  instr_count
);

  localparam int PC_W = ADDR_WIDTH + 1;
  localparam logic [PC_W-1:0] END_PC  = PC_W'(PROG_END);
  localparam logic [3:0]      OP_CLR  = 4'h7;
  localparam logic [3:0]      OP_SNZA = 4'h8;
  localparam logic [3:0]      OP_SNZS = 4'h9;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_SKIP  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                r_state;
  logic [PC_W-1:0]       r_pc;
  logic [3:0]            r_ir;
  logic [CNT_WIDTH-1:0]  r_count;
  logic                  r_valid;
  logic                  r_busy;
  logic                  r_done;

  state_t                w_state_nxt;
  logic [PC_W-1:0]       w_pc_nxt;
  logic [3:0]            w_ir_nxt;
  logic [CNT_WIDTH-1:0]  w_count_nxt;
  logic                  w_step_ok;
  logic                  w_is_skip;
  logic                  w_flag;

`ifdef SEQ_SINGLE_STEP_EN
  assign w_step_ok = !step_en || step;
`else
  assign w_step_ok = 1'b1;
`endif

  assign w_is_skip = (romData == OP_SNZA) || (romData == OP_SNZS);
  assign w_flag    = (r_ir == OP_SNZS) ? zero_s : zero_a;

  // The PC carries one extra bit so overflow past the last address ends the
  // program; the visible address saturates instead of wrapping to 0.
  assign romAddr     = r_pc[ADDR_WIDTH] ? {ADDR_WIDTH{1'b1}} : r_pc[ADDR_WIDTH-1:0];
  assign instr_valid = r_valid;
  assign instr_op    = r_ir;
  assign busy        = r_busy;
  assign done        = r_done;
  assign instr_count = r_count;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_nxt    = r_ir;
    w_count_nxt = r_count;
    if (abort) begin
      w_state_nxt = S_IDLE;
      w_pc_nxt    = {PC_W{1'b0}};
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            w_state_nxt = S_FETCH;
            w_pc_nxt    = {PC_W{1'b0}};
            w_count_nxt = {CNT_WIDTH{1'b0}};
          end else begin
            w_state_nxt = r_state;
          end
        end
        S_FETCH: begin
          if (r_pc >= END_PC) begin
            w_state_nxt = S_DONE;
          end else begin
            w_ir_nxt = romData;
            if (!w_step_ok) begin
              w_state_nxt = S_FETCH;
            end else if (w_is_skip) begin
              w_state_nxt = S_SKIP;
            end else begin
              w_state_nxt = S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (instr_ready) begin
            w_state_nxt = S_FETCH;
            w_pc_nxt    = r_pc + PC_W'(1);
            if (r_count == {CNT_WIDTH{1'b1}}) begin
              w_count_nxt = r_count;
            end else begin
              w_count_nxt = r_count + CNT_WIDTH'(1);
            end
          end else begin
            w_state_nxt = S_ISSUE;
          end
        end
        S_SKIP: begin
          // A clear zero flag means the tested register is non-zero: skip one.
          w_state_nxt = S_FETCH;
          if (w_flag) begin
            w_pc_nxt = r_pc + PC_W'(1);
          end else begin
            w_pc_nxt = r_pc + PC_W'(2);
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pc    <= {PC_W{1'b0}};
      r_ir    <= OP_CLR;
      r_count <= {CNT_WIDTH{1'b0}};
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ir    <= w_ir_nxt;
      r_count <= w_count_nxt;
      r_valid <= (w_state_nxt == S_ISSUE);
      r_busy  <= (w_state_nxt == S_FETCH) || (w_state_nxt == S_ISSUE) ||
                 (w_state_nxt == S_SKIP);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

endmodule
